// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// slave: the unit itself; master: the core and memory around it.
interface load_store_unit_if;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_rw;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_valid, cpu_rw, cpu_funct3, cpu_addr, cpu_wdata,
    input  mem_ack, mem_rdata,
    output cpu_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output cpu_valid, cpu_rw, cpu_funct3, cpu_addr, cpu_wdata,
    output mem_ack, mem_rdata,
    input  cpu_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: aligns stores onto byte lanes,
// extends loads, flags misaligned/illegal accesses and bus timeouts.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  load_store_unit_if.slave     bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic        rw_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [CW-1:0] cnt_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        legal;
  logic        in_req;
  logic        hit_to;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;
  logic [3:0]  be;
  logic [31:0] wrep;

  assign accept = bus.cpu_valid && (state_q == IDLE);
  assign in_req = (state_q == REQ);
  assign hit_to = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    legal = 1'b0;
    unique case (bus.cpu_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~bus.cpu_addr[0];
      3'b010:  legal = (bus.cpu_addr[1:0] == 2'b00);
      3'b100:  legal = ~bus.cpu_rw;
      3'b101:  legal = ~bus.cpu_rw & ~bus.cpu_addr[0];
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = legal ? REQ : RESP;
      REQ:     if (bus.mem_ack || hit_to) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_v = bus.mem_rdata[7:0];
    unique case (addr_q[1:0])
      2'b00:   byte_v = bus.mem_rdata[7:0];
      2'b01:   byte_v = bus.mem_rdata[15:8];
      2'b10:   byte_v = bus.mem_rdata[23:16];
      default: byte_v = bus.mem_rdata[31:24];
    endcase
    half_v = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ext = bus.mem_rdata;
    unique case (f3_q)
      3'b000:  ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext = {{16{half_v[15]}}, half_v};
      3'b100:  ext = {24'h0, byte_v};
      3'b101:  ext = {16'h0, half_v};
      default: ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    be   = 4'b1111;
    wrep = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        be   = 4'b0001 << addr_q[1:0];
        wrep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = 4'b0011 << addr_q[1:0];
        wrep = {2{wdata_q[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else if (accept) begin
      rw_q    <= bus.cpu_rw;
      f3_q    <= bus.cpu_funct3;
      addr_q  <= bus.cpu_addr;
      wdata_q <= bus.cpu_wdata;
      cnt_q   <= '0;
      err_q   <= ~legal;
      rdata_q <= 32'h0;
    end else if (in_req) begin
      // ack wins over a timeout landing in the same cycle
      if (bus.mem_ack) begin
        err_q   <= 1'b0;
        rdata_q <= rw_q ? 32'h0 : ext;
      end else if (hit_to) begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.cpu_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_err   = (state_q == RESP) & err_q;
  assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req & rw_q;
  assign bus.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.mem_wdata = in_req ? wrep : 32'h0;
  assign bus.mem_be    = in_req ? be : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: scoreboard of expected responses,
// popped by a monitor whenever rsp_valid is seen.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;

  logic [32:0] sb[$];

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got err=%b rdata=%h expected none",
                 bus.rsp_err, bus.rsp_rdata);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        if ({bus.rsp_err, bus.rsp_rdata} !== e) begin
          errors++;
          $display("FAIL rsp: got err=%b rdata=%h expected err=%b rdata=%h",
                   bus.rsp_err, bus.rsp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic rw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_valid  = 1'b1;
    bus.cpu_rw     = rw;
    bus.cpu_funct3 = f3;
    bus.cpu_addr   = addr;
    bus.cpu_wdata  = wd;
  endtask

  task automatic access(input logic rw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] mrd,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    sb.push_back({exp_err, exp_rd});
    chk("ready_idle", 32'(bus.cpu_ready), 1);
    drive(rw, f3, addr, wd);
    step();
    bus.cpu_valid = 1'b0;
    if (exp_err) begin
      chk("err_no_req", 32'(bus.mem_req), 0);
      chk("err_rsp_lat", 32'(bus.rsp_valid), 1);
      step();
    end else begin
      chk("req_on", 32'(bus.mem_req), 1);
      chk("req_we", 32'(bus.mem_we), 32'(rw));
      chk("req_addr", bus.mem_addr, {addr[31:2], 2'b00});
      chk("req_be", 32'(bus.mem_be), 32'(exp_be));
      if (rw) chk("req_wdata", bus.mem_wdata, exp_wd);
      repeat (waits) begin
        step();
        chk("hold_req", 32'(bus.mem_req), 1);
        chk("hold_be", 32'(bus.mem_be), 32'(exp_be));
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = mrd;
      step();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
      chk("ack_drop", 32'(bus.mem_req), 0);
      chk("rsp_lat", 32'(bus.rsp_valid), 1);
      step();
    end
    chk("back_idle", 32'(bus.cpu_ready), 1);
  endtask

  initial begin
    bus.cpu_valid  = 1'b0;
    bus.cpu_rw     = 1'b0;
    bus.cpu_funct3 = 3'b000;
    bus.cpu_addr   = 32'h0;
    bus.cpu_wdata  = 32'h0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;

    #3;
    chk("rst_ready", 32'(bus.cpu_ready), 1);
    chk("rst_req", 32'(bus.mem_req), 0);
    chk("rst_rsp", 32'(bus.rsp_valid), 0);
    chk("rst_be", 32'(bus.mem_be), 0);
    chk("rst_addr", bus.mem_addr, 0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // lb / sh / sb / lbu / lh / sw
    access(1'b0, 3'b000, 32'h13, 32'h0, 2, 32'h80FF_0000,
           1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0);
    access(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 0, 32'h0,
           1'b0, 32'h0, 4'b1100, 32'hBEEF_BEEF);
    access(1'b1, 3'b000, 32'h41, 32'h1234_565A, 1, 32'h0,
           1'b0, 32'h0, 4'b0010, 32'h5A5A_5A5A);
    access(1'b0, 3'b100, 32'h02, 32'h0, 0, 32'h00A5_0000,
           1'b0, 32'h0000_00A5, 4'b0100, 32'h0);
    access(1'b0, 3'b001, 32'h00, 32'h0, 3, 32'h1234_F00D,
           1'b0, 32'hFFFF_F00D, 4'b0011, 32'h0);
    access(1'b1, 3'b010, 32'h08, 32'hCAFE_F00D, 0, 32'h0,
           1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D);

    // misaligned / illegal encodings
    access(1'b0, 3'b010, 32'h06, 32'h0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
    access(1'b0, 3'b011, 32'h00, 32'h0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
    access(1'b1, 3'b100, 32'h00, 32'h0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
    access(1'b0, 3'b001, 32'h01, 32'h0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
    access(1'b0, 3'b110, 32'h00, 32'h0, 0, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);

    // timeout then a clean lhu
    sb.push_back({1'b1, 32'h0});
    drive(1'b0, 3'b101, 32'h02, 32'h0);
    step();
    bus.cpu_valid = 1'b0;
    n = 0;
    while (bus.mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    chk("to_len", n, 16);
    chk("to_rsp", 32'(bus.rsp_valid), 1);
    step();
    access(1'b0, 3'b101, 32'h02, 32'h0, 0, 32'h8001_0000,
           1'b0, 32'h0000_8001, 4'b1100, 32'h0);

    // ack on the last allowed cycle beats the timeout
    access(1'b0, 3'b010, 32'h08, 32'h0, 15, 32'h1234_5678,
           1'b0, 32'h1234_5678, 4'b1111, 32'h0);

    // ack while idle is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    step();
    bus.mem_ack   = 1'b0;
    chk("idle_ack_ready", 32'(bus.cpu_ready), 1);
    chk("idle_ack_rsp", 32'(bus.rsp_valid), 0);

    // reset during REQ
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    step();
    bus.cpu_valid = 1'b0;
    chk("rreq_on", 32'(bus.mem_req), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_req", 32'(bus.mem_req), 0);
    chk("async_ready", 32'(bus.cpu_ready), 1);
    #2 rst = 1'b0;
    step();
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    chk("post_rst_req", 32'(bus.mem_req), 0);
    chk("post_rst_rsp", 32'(bus.rsp_valid), 0);
    chk("post_rst_ready", 32'(bus.cpu_ready), 1);

    // back-to-back lw, second held during RESP
    sb.push_back({1'b0, 32'h1122_3344});
    sb.push_back({1'b0, 32'h5566_7788});
    drive(1'b0, 3'b010, 32'h0, 32'h0);
    step();
    bus.cpu_valid = 1'b0;
    chk("b2b_addr0", bus.mem_addr, 32'h0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1122_3344;
    step();
    bus.mem_ack   = 1'b0;
    chk("b2b_rsp0", 32'(bus.rsp_valid), 1);
    drive(1'b0, 3'b010, 32'h4, 32'h0);
    chk("b2b_resp_busy", 32'(bus.cpu_ready), 0);
    step();
    chk("b2b_not_taken", 32'(bus.mem_req), 0);
    chk("b2b_ready", 32'(bus.cpu_ready), 1);
    step();
    bus.cpu_valid = 1'b0;
    chk("b2b_req1", 32'(bus.mem_req), 1);
    chk("b2b_addr1", bus.mem_addr, 32'h4);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5566_7788;
    step();
    bus.mem_ack   = 1'b0;
    chk("b2b_rsp1", 32'(bus.rsp_valid), 1);
    repeat (3) step();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
